// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: one /2../16 divided clock plus a rise-aligned tick,
// with ratio changes applied only at period boundaries and glitch-free start/stop.
module clk_div_ctrl #(
    parameter logic [1:0] DEFAULT_SEL = 2'd0,
    parameter int         CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       cfg_valid_i,
    input  logic [1:0] cfg_sel_i,
    output logic       cfg_ready_o,
    output logic       div_clk_o,
    output logic       tick_o,
    output logic       running_o,
    output logic [1:0] cur_sel_o
);

    localparam logic [1:0] STOP  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PEND  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] halfLast;
    logic             divClk_q, divClk_d;
    logic             tick_q, tick_d;
    logic             running_q;
    logic [1:0]       curSel_q, curSel_d;
    logic [1:0]       pendSel_q, pendSel_d;
    logic             phaseEnd, falling, xfer;

    // Half-period bookkeeping for the ratio currently in force.
    always_comb begin
        halfLast = CNT_W'((4'd1 << curSel_q) - 4'd1);
        phaseEnd = (cnt_q == halfLast);
        falling  = phaseEnd && divClk_q;
        xfer     = cfg_valid_i && (state_q != PEND);
    end

    // Free-running count is the default; each state only overrides what differs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = phaseEnd ? '0 : cnt_q + 1'b1;
        divClk_d  = phaseEnd ? ~divClk_q : divClk_q;
        tick_d    = phaseEnd && !divClk_q;
        curSel_d  = curSel_q;
        pendSel_d = pendSel_q;

        case (state_q)
            STOP: begin
                cnt_d    = '0;
                divClk_d = 1'b0;
                tick_d   = 1'b0;
                if (xfer) begin
                    curSel_d = cfg_sel_i;
                end
                if (en_i) begin
                    state_d = RUN;
                end
            end

            // DRAIN always holds divClk_q high, so the first branch only fires from RUN.
            RUN, DRAIN: begin
                if (!en_i && !divClk_q) begin
                    state_d  = STOP;
                    cnt_d    = '0;
                    divClk_d = 1'b0;
                    tick_d   = 1'b0;
                    if (xfer) begin
                        curSel_d = cfg_sel_i;
                    end
                end else if (xfer && falling) begin
                    curSel_d  = cfg_sel_i;
                    pendSel_d = cfg_sel_i;
                    state_d   = en_i ? RUN : STOP;
                end else if (xfer) begin
                    pendSel_d = cfg_sel_i;
                    state_d   = PEND;
                end else if (falling) begin
                    state_d = en_i ? RUN : STOP;
                end else begin
                    state_d = en_i ? RUN : DRAIN;
                end
            end

            PEND: begin
                if (!en_i && !divClk_q) begin
                    state_d  = STOP;
                    cnt_d    = '0;
                    divClk_d = 1'b0;
                    tick_d   = 1'b0;
                    curSel_d = pendSel_q;
                end else if (falling) begin
                    curSel_d = pendSel_q;
                    state_d  = en_i ? RUN : STOP;
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STOP;
            cnt_q     <= '0;
            divClk_q  <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            curSel_q  <= DEFAULT_SEL;
            pendSel_q <= DEFAULT_SEL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divClk_q  <= divClk_d;
            tick_q    <= tick_d;
            running_q <= (state_d != STOP);
            curSel_q  <= curSel_d;
            pendSel_q <= pendSel_d;
        end
    end

    assign cfg_ready_o = (state_q != PEND);
    assign div_clk_o   = divClk_q;
    assign tick_o      = tick_q;
    assign running_o   = running_q;
    assign cur_sel_o   = curSel_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: a phase-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_clk_div_ctrl;

    localparam logic [1:0] DEFAULT_SEL = 2'd0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfgValid = 1'b0;
    logic [1:0] cfgSel = 2'd0;
    logic       cfgReady, divClk, tick, running;
    logic [1:0] curSel;

    int  checkCount = 0;
    int  errorCount = 0;
    bit  checkEnable = 0;

    // Reference model: a phase is a level plus how many cycles of it have elapsed.
    bit          mRun, mLevel, mTick, mPendValid;
    bit [1:0]    mSel, mPendSel;
    int unsigned mElapsed;

    clk_div_ctrl #(.DEFAULT_SEL(DEFAULT_SEL), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en_i(en), .cfg_valid_i(cfgValid), .cfg_sel_i(cfgSel),
        .cfg_ready_o(cfgReady), .div_clk_o(divClk), .tick_o(tick),
        .running_o(running), .cur_sel_o(curSel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mRun = 0; mLevel = 0; mTick = 0; mElapsed = 0;
        mPendValid = 0; mSel = DEFAULT_SEL; mPendSel = DEFAULT_SEL;
    endtask

    task automatic modelStep();
        bit          xfer;
        int unsigned half;
        xfer = cfgValid && !mPendValid;
        half = 32'd1 << mSel;
        if (!mRun) begin
            mTick = 0;
            if (xfer) mSel = cfgSel;
            if (en) begin
                mRun = 1; mLevel = 0; mElapsed = 0;
            end
        end else if (!en && !mLevel) begin
            mRun = 0; mTick = 0; mElapsed = 0;
            if (mPendValid) mSel = mPendSel;
            if (xfer) mSel = cfgSel;
            mPendValid = 0;
        end else begin
            if (xfer) begin
                mPendValid = 1; mPendSel = cfgSel;
            end
            if (mElapsed + 1 == half) begin
                mElapsed = 0;
                mLevel = !mLevel;
                mTick = mLevel;
                if (!mLevel) begin
                    if (mPendValid) begin
                        mSel = mPendSel; mPendValid = 0;
                    end
                    if (!en) mRun = 0;
                end
            end else begin
                mElapsed++;
                mTick = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else modelStep();
    end

    // Outputs are compared on the falling edge, well clear of the active edge.
    always @(negedge clk) begin
        if (checkEnable && !rst) begin
            checkOutput("model_div_clk", divClk, mLevel);
            checkOutput("model_tick", tick, mTick);
            checkOutput("model_cfg_ready", cfgReady, !mPendValid);
            checkOutput("model_running", running, mRun);
            checkOutput("model_cur_sel", curSel, mSel);
        end
    end

    task automatic applyStimulus(input logic enVal, input logic validVal, input logic [1:0] selVal);
        @(negedge clk);
        #1;
        en = enVal;
        cfgValid = validVal;
        cfgSel = selVal;
    endtask

    task automatic holdUntilDiv(input logic enVal, input logic target, input string tag, output int waited);
        bit found;
        found = 0;
        waited = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            applyStimulus(enVal, 1'b0, 2'd0);
            waited++;
            if (divClk === target) found = 1;
        end
        checkOutput({tag, "_seen"}, found, 1);
    endtask

    task automatic holdUntilStopped(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0);
            if (running === 1'b0) found = 1;
        end
        checkOutput({tag, "_seen"}, found, 1);
    endtask

    initial begin
        int         waited;
        logic [9:0] wave;
        logic       enR;

        repeat (2) @(negedge clk);
        #1;
        rst = 0;
        checkOutput("reset_div_clk", divClk, 0);
        checkOutput("reset_cfg_ready", cfgReady, 1);
        checkOutput("reset_running", running, 0);
        checkEnable = 1;

        $display("[TB] /2 run from reset");
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("div2_entry_running", running, 1);
        checkOutput("div2_entry_low", divClk, 0);
        applyStimulus(1, 0, 0);
        checkOutput("div2_first_rise", divClk, 1);
        checkOutput("div2_first_tick", tick, 1);
        applyStimulus(1, 0, 0);
        checkOutput("div2_fall", divClk, 0);
        checkOutput("div2_no_tick", tick, 0);
        applyStimulus(1, 0, 0);
        checkOutput("div2_second_rise", divClk, 1);

        $display("[TB] asynchronous reset mid-cycle");
        #1 rst = 1;
        #1;
        checkOutput("async_rst_div_clk", divClk, 0);
        checkOutput("async_rst_tick", tick, 0);
        checkOutput("async_rst_cfg_ready", cfgReady, 1);
        checkOutput("async_rst_running", running, 0);
        checkOutput("async_rst_cur_sel", curSel, DEFAULT_SEL);
        applyStimulus(0, 0, 0);
        rst = 0;

        $display("[TB] /16 to /2 switch inside a high phase");
        applyStimulus(1, 1, 3);
        applyStimulus(1, 0, 0);
        checkOutput("div16_cur_sel", curSel, 3);
        holdUntilDiv(1, 1, "div16_rise", waited);
        checkOutput("div16_low_len", waited, 8);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        checkOutput("switch_ready_low", cfgReady, 0);
        checkOutput("switch_sel_held", curSel, 3);
        holdUntilDiv(1, 0, "div16_fall", waited);
        checkOutput("div16_high_len", 2 + waited, 8);
        checkOutput("switch_sel_applied", curSel, 0);
        checkOutput("switch_ready_back", cfgReady, 1);
        applyStimulus(1, 0, 0);
        checkOutput("after_switch_high", divClk, 1);
        applyStimulus(1, 0, 0);
        checkOutput("after_switch_low", divClk, 0);

        $display("[TB] second offer while pending");
        applyStimulus(1, 0, 0);
        checkOutput("collide_pre_high", divClk, 1);
        applyStimulus(1, 1, 3);
        applyStimulus(1, 1, 2);
        checkOutput("collide_ready_low", cfgReady, 0);
        applyStimulus(1, 0, 0);
        checkOutput("collide_sel_first", curSel, 3);
        checkOutput("collide_ready_back", cfgReady, 1);

        $display("[TB] stop during high and low phases at /8");
        holdUntilStopped("stop_before_div8");
        applyStimulus(1, 1, 2);
        applyStimulus(1, 0, 0);
        holdUntilDiv(1, 1, "div8_rise", waited);
        holdUntilDiv(0, 0, "div8_drain_fall", waited);
        checkOutput("div8_drain_high_len", waited, 4);
        checkOutput("div8_drain_stopped", running, 0);
        applyStimulus(0, 0, 0);
        checkOutput("div8_held_low", divClk, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("div8_restart_running", running, 1);
        applyStimulus(0, 0, 0);
        checkOutput("div8_low_running", running, 1);
        applyStimulus(0, 0, 0);
        checkOutput("div8_low_stop_running", running, 0);
        checkOutput("div8_low_stop_div", divClk, 0);

        $display("[TB] drain and resume at /4");
        applyStimulus(1, 1, 1);
        wave = '0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus((k == 3) ? 1'b0 : 1'b1, 1'b0, 2'd0);
            wave = {wave[8:0], divClk};
            if (k == 4) checkOutput("drain_running", running, 1);
        end
        checkOutput("drain_resume_wave", wave, 10'b0011001100);

        $display("[TB] randomized traffic");
        enR = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) enR = ~enR;
            applyStimulus(enR, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
        end
        applyStimulus(0, 0, 0);
        repeat (2) @(negedge clk);

        checkEnable = 0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
